monsopc_leds: RTL and testbench

- Avalon-MM slave output PIO: the write-side counterpart of the button input PIO.
- Drives a WIDTH-bit output port (board LEDs) from a CPU-writable data register.
- Atomic bit-set and bit-clear registers allow single-bit updates without read-modify-write.
- Hardware blink engine toggles masked bits at a programmable rate.
- Sits on the SOPC interconnect next to the button PIO: 2-bit word address, 32-bit data, registered read data.

---
 rtl/monsopc_leds.sv | 101 ++++++++++
 tb/tb_monsopc_leds.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/monsopc_leds.sv
// Avalon-MM output PIO for board LEDs: data register with atomic set/clear and an optional blink engine.
// Optional blink engine (BLINK_MASK register, counter, phase) is built when MONSOPC_LEDS_BLINK_EN is defined.
module monsopc_leds #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] blink_bits;
  logic [WIDTH-1:0] rd_mux;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign wr_bits     = writedata[WIDTH-1:0];
  assign unused_bits = ^writedata;

  // Data register: plain write, atomic set, atomic clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RST_DATA;
    end else if (wr_en) begin
      case (address)
        2'd0:    data <= wr_bits;
        2'd2:    data <= data | wr_bits;
        2'd3:    data <= data & ~wr_bits;
        default: data <= data;
      endcase
    end
  end

`ifdef MONSOPC_LEDS_BLINK_EN
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [WIDTH-1:0] blink_mask;
  logic [CNT_W-1:0] blink_cnt;
  logic             phase;

  // A mask write restarts the half-period and wins over a coincident wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
    end else if (wr_en && address == 2'd1) begin
      blink_mask <= wr_bits;
      blink_cnt  <= '0;
      phase      <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt  <= '0;
      phase      <= ~phase;
    end else begin
      blink_cnt  <= blink_cnt + CNT_W'(1);
    end
  end

  assign blink_bits = blink_mask & {WIDTH{phase}};
`else
  logic [31:0] unused_cfg;
  logic [WIDTH-1:0] blink_mask;

  assign unused_cfg = 32'(BLINK_DIV);
  assign blink_mask = '0;
  assign blink_bits = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = data;
      2'd1:    rd_mux = blink_mask;
      default: rd_mux = '0;
    endcase
  end

  // Read data is captured every cycle regardless of chipselect; LEDs lag data by one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= RST_DATA;
    end else begin
      readdata <= 32'(rd_mux);
      out_port <= data ^ blink_bits;
    end
  end

endmodule

// File: tb/tb_monsopc_leds.sv
// Self-checking bench for monsopc_leds: directed vector table, blink corner sequences and random traffic vs. a model.
module tb_monsopc_leds;

  localparam int unsigned DIV = 4;
  localparam logic [7:0]  RV  = 8'h5A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks = 0;
  int errors = 0;

  // Reference state: counter and phase are derived from edges since the last clear.
  logic [7:0] m_data;
  logic [7:0] m_mask;
  int         m_k;

  monsopc_leds #(.WIDTH(8), .RESET_VALUE(32'(RV)), .BLINK_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a;
    logic        c;
    logic        w;
    logic [31:0] d;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit m_phase();
    return ((m_k / DIV) % 2) != 0;
  endfunction

  task automatic m_reset();
    m_data = RV;
    m_mask = 8'h00;
    m_k    = 0;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
  task automatic step(input logic [1:0] a, input logic c, input logic w, input logic [31:0] d);
    logic [7:0]  nxt_out;
    logic [31:0] nxt_rd;
    address = a; chipselect = c; write_n = w; writedata = d;
    nxt_rd  = (a == 2'd0) ? {24'h0, m_data} : (a == 2'd1) ? {24'h0, m_mask} : 32'h0;
    nxt_out = m_data ^ (m_mask & {8{m_phase()}});
    @(posedge clk);
    m_k++;
    if (c && !w) begin
      case (a)
        2'd0: m_data = d[7:0];
        2'd1: begin
`ifdef MONSOPC_LEDS_BLINK_EN
          m_mask = d[7:0];
          m_k    = 0;
`endif
        end
        2'd2: m_data = m_data | d[7:0];
        default: m_data = m_data & ~d[7:0];
      endcase
    end
    @(negedge clk);
    check("out_port", {24'h0, out_port}, {24'h0, nxt_out});
    check("readdata", readdata, nxt_rd);
  endtask

  task automatic idle(input logic [1:0] a);
    step(a, 1'b0, 1'b1, 32'h0);
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,         8'h5A, 32'h5A};
    vecs[1]  = '{2'd0, 1'b1, 1'b0, 32'hFFFF_FF3C, 8'h5A, 32'h5A};
    vecs[2]  = '{2'd0, 1'b0, 1'b1, 32'h0,         8'h3C, 32'h3C};
    vecs[3]  = '{2'd2, 1'b1, 1'b0, 32'h81,        8'h3C, 32'h0};
    vecs[4]  = '{2'd0, 1'b0, 1'b1, 32'h0,         8'hBD, 32'hBD};
    vecs[5]  = '{2'd3, 1'b1, 1'b0, 32'h0C,        8'hBD, 32'h0};
    vecs[6]  = '{2'd0, 1'b0, 1'b1, 32'h0,         8'hB1, 32'hB1};
    vecs[7]  = '{2'd2, 1'b0, 1'b1, 32'h0,         8'hB1, 32'h0};
    vecs[8]  = '{2'd3, 1'b0, 1'b1, 32'h0,         8'hB1, 32'h0};
    vecs[9]  = '{2'd0, 1'b0, 1'b0, 32'h0,         8'hB1, 32'hB1};
    vecs[10] = '{2'd0, 1'b1, 1'b1, 32'h0,         8'hB1, 32'hB1};
    vecs[11] = '{2'd0, 1'b0, 1'b1, 32'h0,         8'hB1, 32'hB1};

    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    m_reset();
    repeat (2) @(negedge clk);
    check("reset out_port", {24'h0, out_port}, {24'h0, RV});
    check("reset readdata", readdata, 32'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].c, vecs[i].w, vecs[i].d);
      check($sformatf("vec%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
    end

`ifdef MONSOPC_LEDS_BLINK_EN
    step(2'd1, 1'b1, 1'b0, 32'h0F);
    for (int j = 1; j <= 12; j++) begin
      idle(2'd1);
      check("blink pattern", {24'h0, out_port}, (((j - 1) / 4) % 2 != 0) ? 32'hBE : 32'hB1);
      check("mask readback", readdata, 32'h0F);
    end
    // Land a mask rewrite on a wrap edge where the phase would otherwise go high.
    for (int i = 0; i < 64 && !((m_k % DIV) == DIV - 1 && !m_phase()); i++) idle(2'd0);
    step(2'd1, 1'b1, 1'b0, 32'h0F);
    for (int j = 1; j <= 6; j++) begin
      idle(2'd0);
      check("wrap clear", {24'h0, out_port}, (j <= 4) ? 32'hB1 : 32'hBE);
    end
`else
    step(2'd1, 1'b1, 1'b0, 32'hFF);
    for (int j = 1; j <= 10; j++) begin
      idle(2'd1);
      check("no blink", {24'h0, out_port}, 32'hB1);
      check("addr1 reads zero", readdata, 32'h0);
    end
`endif

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 reset_n = 1'b0;
        #1;
        check("async reset out_port", {24'h0, out_port}, {24'h0, RV});
        check("async reset readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
      end
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
